vic_sound_ctrl: RTL and testbench
=================================

// Module: vic_sound_ctrl
// PURPOSE
//  CPU-facing controller for the VIC sound generator registers $900A-$900E.
//  Buffers CPU writes in a small FIFO and commits at most one per i_ena4 tick.
//  Drives the four voice bytes and the amplitude into the audio datapath.
//  Slews amplitude changes one step at a time to avoid clicks.
// PARAMETERS
//  SLEW_DIV    1024  i_ena4 ticks per +/-1 amplitude step (>=1)
//  FIFO_DEPTH  4     pending-write entries (power of 2, >=2)
// PORTS
//  i_clk            in   1  system clock, single domain
//  i_rst_n          in   1  reset: asynchronous, active-low
//  i_ena4           in   1  clock enable, same strobe that feeds the sound datapath
//  i_cs             in   1  VIC register select
//  i_we             in   1  write strobe; a write is i_cs&i_we in one i_clk cycle
//  i_addr           in   4  register offset; 0xA..0xE handled here
//  i_data           in   8  write data
//  o_data           out  8  readback of committed register (comb. from regs)
//  o_busy           out  1  FIFO full; writes this cycle are dropped unless a pop coincides
//  o_base_sound     out  8  committed $900A
//  o_alto_sound     out  8  committed $900B
//  o_soprano_sound  out  8  committed $900C
//  o_noise_sound    out  8  committed $900D
//  o_aux_colour     out  4  committed $900E[7:4]
//  o_amplitude      out  4  amplitude to the datapath (slewed)
// BEHAVIOUR
//  Reset: all committed regs 0x00, o_amplitude 0, FIFO empty, o_busy 0, FSM IDLE.
//  Push: i_cs&i_we with i_addr in 0xA..0xE pushes {addr[2:0],data}.
//   Other addresses are ignored.
//  Full: a push is dropped when full, unless a pop occurs in the same cycle;
//   then the push is accepted.
//  Simultaneous push+pop: both happen; the count is unchanged.
//  Pop/commit: in a cycle with i_ena4=1 and the FIFO non-empty (state at the
//   clock edge), pop the head and write the target reg at that edge.
//   Latency: write at edge N -> earliest commit at edge N+1.
//  Ordering: commits are in write order. Two writes to the same address both
//   commit, one per tick, so the last write wins.
//  Readback: i_cs&!i_we, addr 0xA..0xE -> committed value.
//   Pending FIFO contents are not visible. All other addresses -> 0xFF.
//  Amplitude target = committed $900E[3:0].
//  Slew FSM (advances only on i_ena4):
//   IDLE: o_amplitude==target.
//     Target above -> RAMP_UP; target below -> RAMP_DOWN; slew_cnt <= SLEW_DIV-1.
//   RAMP_UP/RAMP_DOWN: decrement slew_cnt. At 0, step o_amplitude by +/-1.
//     If it now equals target -> IDLE; else reload slew_cnt.
//   Target change mid-ramp: direction is re-evaluated at each step.
//     If the target is crossed or reached on a step -> IDLE, then re-ramp.
//     o_amplitude never leaves 0..15 (no wrap).
//  Reset mid-operation: immediate return to reset values.
//   Pending FIFO writes are lost.
//  The sound datapath sees new voice values exactly one i_clk after commit.
// CONFIGURATION
//  VIC_SOUND_SLEW_EN defined: slew FSM and counter built as above.
//  Not defined: no FSM or counter; o_amplitude is a register loaded with
//   $900E[3:0] on the commit edge (same timing as the voice regs).
//   SLEW_DIV is unused.
// TESTING
//  1. Reset release; write 0xA=0x87 at cycle 0 with i_ena4 every 4th cycle.
//     -> o_base_sound=0x87 after the first i_ena4 edge >= cycle 1.
//     -> Read 0xA returns 0x87; read 0x9 returns 0xFF.
//  2. Five back-to-back writes, no i_ena4 (FIFO_DEPTH=4).
//     -> o_busy=1 after the 4th write; the 5th is dropped.
//     -> Four i_ena4 pulses then commit 4 values in order.
//  3. FIFO full, i_ena4=1 and a write in the same cycle.
//     -> The write is accepted; the count stays 4.
//  4. SLEW_EN, SLEW_DIV=2: write 0xE=0x03.
//     -> o_amplitude goes 0->1->2->3, one step per 2 i_ena4 ticks, then IDLE.
//     -> Write 0xE=0x01 mid-ramp at amp=2 -> next step goes to 1, then IDLE.
//  5. Without SLEW_EN: write 0xE=0xAF.
//     -> o_amplitude=0xF and o_aux_colour=0xA on the same commit edge.
//  6. Assert i_rst_n low mid-ramp with the FIFO non-empty.
//     -> All outputs 0 asynchronously; after release no stale commits occur.

Source files
------------

// File: rtl/vic_sound_ctrl.sv
// VIC sound register controller ($900A-$900E): write FIFO, one commit per i_ena4 tick, amplitude output.
// Build option VIC_SOUND_SLEW_EN: slews o_amplitude toward $900E[3:0] one step per SLEW_DIV ticks.
module vic_sound_ctrl #(
   parameter int unsigned SLEW_DIV   = 1024,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ena4,
   input  logic       i_cs,
   input  logic       i_we,
   input  logic [3:0] i_addr,
   input  logic [7:0] i_data,
   output logic [7:0] o_data,
   output logic       o_busy,
   output logic [7:0] o_base_sound,
   output logic [7:0] o_alto_sound,
   output logic [7:0] o_soprano_sound,
   output logic [7:0] o_noise_sound,
   output logic [3:0] o_aux_colour,
   output logic [3:0] o_amplitude
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned SW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;

   logic [10:0] r_fifo [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic [7:0] r_base;
   logic [7:0] r_alto;
   logic [7:0] r_soprano;
   logic [7:0] r_noise;
   logic [7:0] r_900e;
   logic [3:0] r_amp;

   logic        w_addr_ok;
   logic        w_full;
   logic        w_pop;
   logic        w_push;
   logic [10:0] w_head;
   logic [3:0]  w_target;

   assign w_addr_ok = (i_addr >= 4'hA) && (i_addr <= 4'hE);
   assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_pop     = i_ena4 && (r_count != '0);
   // A pop in the same cycle frees a slot, so a push against a full FIFO is still accepted.
   assign w_push    = i_cs && i_we && w_addr_ok && (!w_full || w_pop);
   assign w_head    = r_fifo[r_rd_ptr];
   assign w_target  = r_900e[3:0];

   always_ff @(posedge i_clk) begin
      if (w_push)
         r_fifo[r_wr_ptr] <= {i_addr[2:0], i_data};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= (r_wr_ptr == AW'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == AW'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_base    <= '0;
         r_alto    <= '0;
         r_soprano <= '0;
         r_noise   <= '0;
         r_900e    <= '0;
      end else if (w_pop) begin
         case (w_head[10:8])
            3'd2:    r_base    <= w_head[7:0];
            3'd3:    r_alto    <= w_head[7:0];
            3'd4:    r_soprano <= w_head[7:0];
            3'd5:    r_noise   <= w_head[7:0];
            3'd6:    r_900e    <= w_head[7:0];
            default: ;
         endcase
      end
   end

`ifdef VIC_SOUND_SLEW_EN
   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_RAMP_UP   = 2'd1;
   localparam logic [1:0] S_RAMP_DOWN = 2'd2;

   logic [1:0]    r_state;
   logic [SW-1:0] r_slew_cnt;
   logic [3:0]    w_amp_next;

   // Direction is taken from the current target at each step, so a target change mid-ramp is followed.
   always_comb begin
      w_amp_next = r_amp;
      if (w_target > r_amp)
         w_amp_next = r_amp + 4'd1;
      else if (w_target < r_amp)
         w_amp_next = r_amp - 4'd1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_slew_cnt <= '0;
         r_amp      <= '0;
      end else if (i_ena4) begin
         case (r_state)
            S_IDLE: begin
               if (w_target > r_amp) begin
                  r_state    <= S_RAMP_UP;
                  r_slew_cnt <= SW'(SLEW_DIV-1);
               end else if (w_target < r_amp) begin
                  r_state    <= S_RAMP_DOWN;
                  r_slew_cnt <= SW'(SLEW_DIV-1);
               end
            end
            default: begin
               if (r_slew_cnt == '0) begin
                  r_amp <= w_amp_next;
                  if (w_amp_next == w_target)
                     r_state <= S_IDLE;
                  else begin
                     r_state    <= (w_target > w_amp_next) ? S_RAMP_UP : S_RAMP_DOWN;
                     r_slew_cnt <= SW'(SLEW_DIV-1);
                  end
               end else begin
                  r_slew_cnt <= r_slew_cnt - 1'b1;
               end
            end
         endcase
      end
   end
`else
   logic w_unused_slew;
   assign w_unused_slew = (SW == 0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_amp <= '0;
      else if (w_pop && (w_head[10:8] == 3'd6))
         r_amp <= w_head[3:0];
   end
`endif

   always_comb begin
      o_data = '1;
      if (i_cs && !i_we) begin
         case (i_addr)
            4'hA:    o_data = r_base;
            4'hB:    o_data = r_alto;
            4'hC:    o_data = r_soprano;
            4'hD:    o_data = r_noise;
            4'hE:    o_data = r_900e;
            default: o_data = '1;
         endcase
      end
   end

   assign o_busy          = w_full;
   assign o_base_sound    = r_base;
   assign o_alto_sound    = r_alto;
   assign o_soprano_sound = r_soprano;
   assign o_noise_sound   = r_noise;
   assign o_aux_colour    = r_900e[7:4];
   assign o_amplitude     = r_amp;

endmodule

// File: tb/tb_vic_sound_ctrl.sv
// Directed bench for vic_sound_ctrl; amplitude checks follow the VIC_SOUND_SLEW_EN build option.
module tb_vic_sound_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena4 = 1'b0;
   logic       cs = 1'b0;
   logic       we = 1'b0;
   logic [3:0] addr = '0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata;
   logic       busy;
   logic [7:0] base_s, alto_s, sop_s, noise_s;
   logic [3:0] aux_c, amp;

   int n_checks = 0;
   int n_fail   = 0;

   vic_sound_ctrl #(
`ifdef VIC_SOUND_SLEW_EN
      .SLEW_DIV  (2),
`endif
      .FIFO_DEPTH(4)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_ena4         (ena4),
      .i_cs           (cs),
      .i_we           (we),
      .i_addr         (addr),
      .i_data         (wdata),
      .o_data         (rdata),
      .o_busy         (busy),
      .o_base_sound   (base_s),
      .o_alto_sound   (alto_s),
      .o_soprano_sound(sop_s),
      .o_noise_sound  (noise_s),
      .o_aux_colour   (aux_c),
      .o_amplitude    (amp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, pass the rising edge, sample 1ns later with inputs idle.
   task automatic cyc(input logic e, input logic c, input logic w,
                      input logic [3:0] a, input logic [7:0] d);
      ena4 = e; cs = c; we = w; addr = a; wdata = d;
      @(posedge clk);
      #1;
      ena4 = 1'b0; cs = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      cyc(1'b0, 1'b1, 1'b1, a, d);
   endtask

   task automatic tick();
      cyc(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] d);
      cs = 1'b1; we = 1'b0; addr = a;
      #1;
      d = rdata;
      cs = 1'b0;
   endtask

   initial begin
      logic [7:0] r;

      // Reset state
      #12;
      chk("rst_base", 16'(base_s), 16'h00);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_amp", 16'(amp), 16'h0);
      chk("rst_aux", 16'(aux_c), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Test 1: write at cycle 0 with i_ena4 on cycles 0,4,...
      for (int c = 0; c <= 4; c++) begin
         cyc((c % 4) == 0, c == 0, c == 0, 4'hA, 8'h87);
         if (c == 0) chk("t1_latency", 16'(base_s), 16'h00);
         if (c == 3) chk("t1_before_tick", 16'(base_s), 16'h00);
      end
      chk("t1_commit", 16'(base_s), 16'h87);
      rd(4'hA, r); chk("t1_read_a", 16'(r), 16'h87);
      rd(4'h9, r); chk("t1_read_9", 16'(r), 16'hFF);
      rd(4'hF, r); chk("t1_read_f", 16'(r), 16'hFF);

      // Test 2: five writes without i_ena4, fifth dropped
      wr(4'hB, 8'h11);
      wr(4'hC, 8'h22);
      wr(4'hD, 8'h33);
      chk("t2_not_busy3", 16'(busy), 16'h0);
      wr(4'hA, 8'h44);
      chk("t2_busy4", 16'(busy), 16'h1);
      wr(4'hB, 8'h55);
      chk("t2_busy5", 16'(busy), 16'h1);
      rd(4'hB, r); chk("t2_pending_hidden", 16'(r), 16'h00);
      tick(); chk("t2_c1_alto", 16'(alto_s), 16'h11);
      chk("t2_c1_busy", 16'(busy), 16'h0);
      tick(); chk("t2_c2_sop", 16'(sop_s), 16'h22);
      tick(); chk("t2_c3_noise", 16'(noise_s), 16'h33);
      chk("t2_c3_base_old", 16'(base_s), 16'h87);
      tick(); chk("t2_c4_base", 16'(base_s), 16'h44);
      tick(); tick();
      chk("t2_dropped", 16'(alto_s), 16'h11);

      // Test 3: full FIFO, pop and push in the same cycle
      wr(4'hA, 8'h01);
      wr(4'hB, 8'h02);
      wr(4'hC, 8'h03);
      wr(4'hD, 8'h04);
      chk("t3_full", 16'(busy), 16'h1);
      cyc(1'b1, 1'b1, 1'b1, 4'hA, 8'h99);
      chk("t3_pop_base", 16'(base_s), 16'h01);
      chk("t3_still_full", 16'(busy), 16'h1);
      tick(); chk("t3_alto", 16'(alto_s), 16'h02);
      tick(); chk("t3_sop", 16'(sop_s), 16'h03);
      tick(); chk("t3_noise", 16'(noise_s), 16'h04);
      tick(); chk("t3_base_last", 16'(base_s), 16'h99);
      chk("t3_empty_busy", 16'(busy), 16'h0);

`ifdef VIC_SOUND_SLEW_EN
      // Test 4: slew with SLEW_DIV=2, then retarget mid-ramp
      wr(4'hE, 8'h03);
      tick(); chk("t4_commit_amp", 16'(amp), 16'h0);   // T0: commit
      tick(); chk("t4_t1", 16'(amp), 16'h0);           // IDLE -> RAMP_UP
      tick(); chk("t4_t2", 16'(amp), 16'h0);
      tick(); chk("t4_t3", 16'(amp), 16'h1);
      tick(); chk("t4_t4", 16'(amp), 16'h1);
      tick(); chk("t4_t5", 16'(amp), 16'h2);
      wr(4'hE, 8'h01);
      tick(); chk("t4_t6", 16'(amp), 16'h2);           // commits 0x01, counter 1->0
      tick(); chk("t4_t7_down", 16'(amp), 16'h1);
      tick(); tick(); tick();
      chk("t4_idle_hold", 16'(amp), 16'h1);
      // Start a new ramp for the reset test
      wr(4'hE, 8'h0C);
      tick(); tick(); tick(); tick();
      chk("t6_ramping", 16'(amp), 16'h2);
`else
      // Test 5: direct amplitude load on the commit edge
      wr(4'hE, 8'hAF);
      chk("t5_pre_amp", 16'(amp), 16'h0);
      chk("t5_pre_aux", 16'(aux_c), 16'h0);
      tick();
      chk("t5_amp", 16'(amp), 16'hF);
      chk("t5_aux", 16'(aux_c), 16'hA);
      rd(4'hE, r); chk("t5_read_e", 16'(r), 16'hAF);
`endif

      // Test 6: asynchronous reset with pending writes
      wr(4'hA, 8'h5A);
      wr(4'hB, 8'h6B);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_base", 16'(base_s), 16'h00);
      chk("t6_rst_alto", 16'(alto_s), 16'h00);
      chk("t6_rst_amp", 16'(amp), 16'h0);
      chk("t6_rst_aux", 16'(aux_c), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      chk("t6_no_stale_base", 16'(base_s), 16'h00);
      chk("t6_no_stale_alto", 16'(alto_s), 16'h00);
      chk("t6_no_stale_amp", 16'(amp), 16'h0);
      chk("t6_busy", 16'(busy), 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
